// File: rtl/tag_ct_accumulator.sv
// Per-tag saturating spike counters, flushed as (tag, ct) transfers on each update_pulse.
// Optional out-of-range drop counter: define TAG_CT_ACC_DROP_CNT_EN.
module tag_ct_accumulator #(
  parameter int Ntag   = 10,
  parameter int Nct    = 10,
  parameter int Nslots = 16,
  parameter int Ndrop  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             update_pulse,
  input  logic             in_v,
  input  logic [Ntag-1:0]  in_tag,
  output logic             in_a,
  output logic             out_v,
  output logic [Ntag-1:0]  out_tag,
  output logic [Nct-1:0]   out_ct,
  input  logic             out_a,
  output logic [Ndrop-1:0] dropped,
  output logic             flushing
);

  localparam int PW = (Nslots > 1) ? $clog2(Nslots) : 1;
  localparam logic [PW-1:0]  LAST_PTR = PW'(Nslots - 1);
  localparam logic [Ntag:0]  SLOTS_L  = (Ntag + 1)'(Nslots);
  localparam logic [Nct-1:0] CT_MAX   = {Nct{1'b1}};

  typedef enum logic [0:0] {ACCUM = 1'b0, FLUSH = 1'b1} state_t;

  state_t         state_r, state_s;
  logic [PW-1:0]  ptr_r, ptr_s;
  logic [Nct-1:0] cnt_r [Nslots];
  logic [Nct-1:0] cur_ct_s;
  logic [PW-1:0]  in_idx_s;
  logic           in_range_s;
  logic           accept_s;
  logic           advance_s;

  // event decode and current scan slot
  always_comb begin
    in_range_s = ({1'b0, in_tag} < SLOTS_L);
    in_idx_s   = in_tag[PW-1:0];
    accept_s   = in_v && (state_r == ACCUM);
    cur_ct_s   = cnt_r[ptr_r];
  end

  // next-state and scan pointer; empty slots are skipped without waiting on out_a
  always_comb begin
    state_s   = state_r;
    ptr_s     = ptr_r;
    advance_s = 1'b0;
    case (state_r)
      ACCUM: begin
        if (update_pulse) begin
          state_s = FLUSH;
          ptr_s   = {PW{1'b0}};
        end else begin
          state_s = ACCUM;
        end
      end
      FLUSH: begin
        advance_s = (cur_ct_s == {Nct{1'b0}}) || out_a;
        if (advance_s) begin
          if (ptr_r == LAST_PTR) begin
            state_s = ACCUM;
            ptr_s   = {PW{1'b0}};
          end else begin
            ptr_s = ptr_r + PW'(1);
          end
        end else begin
          ptr_s = ptr_r;
        end
      end
      default: begin
        state_s = ACCUM;
        ptr_s   = {PW{1'b0}};
      end
    endcase
  end

  // state and pointer registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ACCUM;
      ptr_r   <= {PW{1'b0}};
    end else begin
      state_r <= state_s;
      ptr_r   <= ptr_s;
    end
  end

  // counter bank: increments only in ACCUM, clears only on a FLUSH advance
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < Nslots; i++) cnt_r[i] <= {Nct{1'b0}};
    end else if (accept_s && in_range_s && (cnt_r[in_idx_s] != CT_MAX)) begin
      cnt_r[in_idx_s] <= cnt_r[in_idx_s] + Nct'(1);
    end else if (advance_s) begin
      cnt_r[ptr_r] <= {Nct{1'b0}};
    end
  end

  // outputs decoded from registered state only
  always_comb begin
    in_a     = (state_r == ACCUM);
    flushing = (state_r == FLUSH);
    if (state_r == FLUSH) begin
      out_v   = (cur_ct_s != {Nct{1'b0}});
      out_tag = Ntag'(ptr_r);
      out_ct  = cur_ct_s;
    end else begin
      out_v   = 1'b0;
      out_tag = {Ntag{1'b0}};
      out_ct  = {Nct{1'b0}};
    end
  end

`ifdef TAG_CT_ACC_DROP_CNT_EN
  logic [Ndrop-1:0] drop_r;

  // saturating count of accepted out-of-range events
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_r <= {Ndrop{1'b0}};
    end else if (accept_s && !in_range_s && (drop_r != {Ndrop{1'b1}})) begin
      drop_r <= drop_r + Ndrop'(1);
    end
  end

  assign dropped = drop_r;
`else
  assign dropped = {Ndrop{1'b0}};
`endif

endmodule

// File: tb/tb_tag_ct_accumulator.sv
// Scoreboard bench for tag_ct_accumulator: model counts pushed at each flush, popped on transfers.
module tb_tag_ct_accumulator;
  localparam int NTAG = 10;
  localparam int NCT = 10;
  localparam int NSLOTS = 16;
  localparam int NDROP = 16;
  localparam int CTMAX = (1 << NCT) - 1;

  logic clk, reset, update_pulse, in_v, in_a, out_v, out_a, flushing;
  logic [NTAG-1:0] in_tag, out_tag;
  logic [NCT-1:0] out_ct;
  logic [NDROP-1:0] dropped;

  int checks = 0;
  int errors = 0;
  int xfers = 0;
  int model[NSLOTS];
  int model_drop = 0;
  bit bp = 1'b0;
  logic [NTAG+NCT-1:0] sb[$];

  tag_ct_accumulator #(.Ntag(NTAG), .Nct(NCT), .Nslots(NSLOTS), .Ndrop(NDROP)) dut (
    .clk(clk), .reset(reset), .update_pulse(update_pulse), .in_v(in_v), .in_tag(in_tag),
    .in_a(in_a), .out_v(out_v), .out_tag(out_tag), .out_ct(out_ct), .out_a(out_a),
    .dropped(dropped), .flushing(flushing)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", name, obs, exp);
    end
  endtask

  // sink: always accepting, or random stalls under backpressure
  initial begin
    out_a = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_a = bp ? ($urandom_range(0, 2) == 0) : 1'b1;
    end
  end

  // monitor: scoreboard pop on each transfer, hold-stability while stalled
  logic hold_prev = 1'b0;
  logic [NTAG-1:0] ptag;
  logic [NCT-1:0] pct;
  always @(negedge clk) begin
    logic [NTAG+NCT-1:0] e;
    check("in_a_vs_flushing", in_a, !flushing);
    if (hold_prev && !reset) begin
      check("hold_v", out_v, 1);
      check("hold_tag", out_tag, ptag);
      check("hold_ct", out_ct, pct);
    end
    if (out_v && out_a && !reset) begin
      xfers++;
      check("xfer_expected", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("xfer_tag", out_tag, e[NTAG+NCT-1:NCT]);
        check("xfer_ct", out_ct, e[NCT-1:0]);
      end
    end
    hold_prev = out_v && !out_a && !reset;
    ptag = out_tag;
    pct = out_ct;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_ev(input int tag);
    if (tag < NSLOTS) begin
      if (model[tag] < CTMAX) model[tag]++;
    end else begin
      model_drop++;
    end
  endtask

  task automatic send(input int tag);
    in_v = 1'b1;
    in_tag = tag[NTAG-1:0];
    tick();
    in_v = 1'b0;
    model_ev(tag);
  endtask

  task automatic pulse(input bit with_ev, input int tag);
    update_pulse = 1'b1;
    if (with_ev) begin
      in_v = 1'b1;
      in_tag = tag[NTAG-1:0];
    end
    tick();
    update_pulse = 1'b0;
    in_v = 1'b0;
    if (with_ev) model_ev(tag);
    for (int i = 0; i < NSLOTS; i++) begin
      if (model[i] != 0) sb.push_back({NTAG'(i), NCT'(model[i])});
      model[i] = 0;
    end
  endtask

  task automatic wait_flush(input string name, input int exp_len, input int x0, input int exp_x);
    int n = 0;
    bit done = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (!flushing) begin
        done = 1'b1;
        break;
      end
      n++;
    end
    check({name, "_done"}, done, 1);
    if (exp_len > 0) check({name, "_len"}, n, exp_len);
    check({name, "_xfers"}, xfers - x0, exp_x);
    check({name, "_sb_empty"}, sb.size(), 0);
    check({name, "_ret_in_a"}, in_a, 1);
  endtask

  function automatic int exp_drop();
`ifdef TAG_CT_ACC_DROP_CNT_EN
    return model_drop;
`else
    return 0;
`endif
  endfunction

  initial begin
    int x0;
    bit seen;
    reset = 1'b1; update_pulse = 1'b0; in_v = 1'b0; in_tag = '0;
    for (int i = 0; i < NSLOTS; i++) model[i] = 0;
    tick(); tick();
    check("rst_in_a", in_a, 1);
    check("rst_out_v", out_v, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_out_ct", out_ct, 0);
    check("rst_dropped", dropped, 0);
    check("rst_flushing", flushing, 0);
    reset = 1'b0;
    tick();

    // basic accumulate and flush, then an empty flush
    send(0); send(0); send(0); send(5);
    x0 = xfers; pulse(1'b0, 0);
    check("flush_start", flushing, 1);
    check("flush_in_a", in_a, 0);
    wait_flush("basic", 16, x0, 2);
    x0 = xfers; pulse(1'b0, 0);
    wait_flush("empty", 16, x0, 0);

    // backpressure
    bp = 1'b1;
    send(1); send(1);
    for (int i = 0; i < 7; i++) send(2);
    send(15);
    x0 = xfers; pulse(1'b0, 0);
    wait_flush("bp", 0, x0, 3);
    bp = 1'b0;

    // saturation
    for (int i = 0; i < CTMAX + 7; i++) send(3);
    x0 = xfers; pulse(1'b0, 0);
    wait_flush("sat", 16, x0, 1);

    // event on the same edge as update_pulse
    x0 = xfers; pulse(1'b1, 4);
    wait_flush("same_edge", 16, x0, 1);

    // out-of-range tags
    send(16); send(17); send(1023);
    check("dropped", dropped, exp_drop());
    x0 = xfers; pulse(1'b0, 0);
    wait_flush("oor", 16, x0, 0);

    // reset after the first transfer of a flush
    send(0); send(0); send(9);
    x0 = xfers; pulse(1'b0, 0);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (xfers - x0 >= 1) begin
        seen = 1'b1;
        break;
      end
    end
    check("rst_mid_first_xfer", seen, 1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    sb.delete();
    for (int i = 0; i < NSLOTS; i++) model[i] = 0;
    model_drop = 0;
    tick();
    reset = 1'b0;
    check("rst_mid_out_v", out_v, 0);
    check("rst_mid_in_a", in_a, 1);
    check("rst_mid_flushing", flushing, 0);
    check("rst_mid_dropped", dropped, exp_drop());
    tick();
    x0 = xfers; pulse(1'b0, 0);
    wait_flush("post_reset", 16, x0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/tag_ct_accumulator.md
# tag_ct_accumulator

Upstream producer for the spike filter array's tag/count input. It accepts single-tag spike events one per cycle and accumulates a per-tag count in a bank of saturating counters. On each `update_pulse` it flushes every nonzero counter as a (tag, ct) transfer on the TagCtChannel consumed by the filter array. It is the transmitter end of that channel and sits between the tag router and the filter array.

## Interface
Parameters:
- `Ntag`, 10: tag width; matches the filter array's `Ntag`.
- `Nct`, 10: count width; matches the filter array's `Nct`.
- `Nslots`, 16: number of counters; tags `0..Nslots-1` are tracked. Range 1 to 2^Ntag.
- `Ndrop`, 16: width of the drop counter.

Ports:
- `clk` input 1: clock.
- `reset` input 1: synchronous, active-high reset.
- `update_pulse` input 1: flush request, one cycle wide.
- `in_v` input 1: event valid.
- `in_tag` input Ntag: event tag.
- `in_a` output 1: event accept.
- `out_v` output 1: TagCtChannel valid.
- `out_tag` output Ntag: TagCtChannel tag.
- `out_ct` output Nct: TagCtChannel count.
- `out_a` input 1: TagCtChannel accept.
- `dropped` output Ndrop: out-of-range tag count.
- `flushing` output 1: high while in FLUSH.

## Operation
- Handshake rule, both channels: a transfer occurs on any rising edge where `v && a`. The sender holds `v` and data stable until that edge.
- States: ACCUM and FLUSH. Reset enters ACCUM with every counter at 0, the scan pointer `ptr` at 0, and `dropped` at 0.
- ACCUM:
  - `in_a = 1`.
  - Accepted event with `in_tag < Nslots`: `cnt[in_tag]` increments, saturating at 2^Nct-1.
  - Accepted event with `in_tag >= Nslots`: counters unchanged; the event is dropped (see Configuration).
- ACCUM → FLUSH: `update_pulse` sampled high. An event accepted on the same edge is counted first and is included in this flush. `ptr` is set to 0.
- FLUSH:
  - `in_a = 0`; input events stall.
  - `out_v = (cnt[ptr] != 0)`, `out_tag = ptr` (zero-extended), `out_ct = cnt[ptr]`.
  - If `cnt[ptr] == 0`: `ptr` increments the next edge, one cycle per empty slot.
  - If `cnt[ptr] != 0`: on transfer, `cnt[ptr]` clears to 0 and `ptr` increments.
  - When `ptr == Nslots-1` advances, the block returns to ACCUM. `ptr` wraps to 0.
- `update_pulse` during FLUSH is ignored.
- `flushing` is high exactly while the state is FLUSH.

## Timing
- Reset values: `in_a = 1`, `out_v = 0`, `out_tag = 0`, `out_ct = 0`, `dropped = 0`, `flushing = 0`.
- `in_a`, `out_v`, `out_tag`, and `out_ct` are decoded from registered state only. There is no combinational path from any input to any output.
- Count latency: an event accepted at edge k is visible in `cnt` after edge k.
- Flush start: `update_pulse` sampled at edge k puts slot 0 on the output during cycle k+1.
- Flush duration: `Nslots` cycles plus the stall cycles spent waiting for `out_a`.
- Return to ACCUM: the last slot's transfer or skip at edge m gives `in_a = 1` in cycle m+1.
- Saturation: a counter at 2^Nct-1 stays at that value. The saturated value is flushed as is.
- Reset mid-FLUSH: next cycle the state is ACCUM, all counters are 0, `out_v = 0`, and undelivered counts are lost.
- Reset while `out_v` is held high: `out_v` deasserts with no transfer.

## Configuration
- `TAG_CT_ACC_DROP_CNT_EN` defined:
  - `dropped` increments on each accepted out-of-range event.
  - It saturates at 2^Ndrop-1 and clears only on reset.
- `TAG_CT_ACC_DROP_CNT_EN` undefined:
  - Out-of-range events are still accepted and discarded.
  - The `dropped` port remains but is tied to 0, and no counter logic is generated.

## Test plan
- Basic accumulate/flush: Nslots=16. Send tag 0 ×3 and tag 5 ×1, then `update_pulse`, with the sink always accepting. Expect exactly two transfers, (0,3) then (5,1), and FLUSH lasting 16 cycles. A second `update_pulse` then yields no transfers.
- Backpressure: the sink inserts 0–10 random stall cycles. Flush of (1,2), (2,7), (15,1) gives the same order and values, with `out_tag`/`out_ct` stable while `out_v && !out_a`. `in_a = 0` throughout FLUSH.
- Saturation: Nct=4. Send tag 3 ×20 then flush. Expect a single transfer (3,15).
- Same-edge event and pulse: an event on tag 4 is accepted on the same edge `update_pulse` is sampled. The flush includes (4,1).
- Out-of-range tags, with `TAG_CT_ACC_DROP_CNT_EN` defined: send tags 16, 17, and 1023. Expect `dropped = 3` and a flush with no transfers. Without the macro, `dropped` stays 0.
- Reset mid-flush: counts on tags 0 and 9; assert `reset` after the (0,ct) transfer. The next cycle has `out_v = 0` and `in_a = 1`, and a subsequent flush yields no transfers.
